// File: rtl/modarith_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle modular add/sub unit among NREQ requesters.
// Latches the winner's operands, runs the unit's start/done handshake under a watchdog, acks the result.
module modarith_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ-1:0]       i_op,
    input  logic [NREQ*WIDTH-1:0] i_a,
    input  logic [NREQ*WIDTH-1:0] i_b,
    output logic [NREQ-1:0]       o_ack,
    output logic [WIDTH-1:0]      o_result,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_unit_start,
    output logic                  o_unit_op,
    output logic [WIDTH-1:0]      o_unit_a,
    output logic [WIDTH-1:0]      o_unit_b,
    input  logic                  i_unit_done,
    input  logic [WIDTH-1:0]      i_unit_result
);
    // state | meaning
    // IDLE  | waiting for a request; grants round-robin from rr_ptr and latches operands
    // ISSUE | o_unit_start pulse, watchdog armed
    // WAIT  | waiting for i_unit_done or watchdog terminal count
    // RESP  | one-cycle o_ack/o_result/o_err to the granted requester
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     grant;
    logic [CW-1:0]     wd_cnt;

    logic              found;
    logic [IW-1:0]     nxt_grant;
    logic              sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    // First pass covers rr_ptr..NREQ-1, second pass wraps to the low indices.
    always_comb begin
        found     = 1'b0;
        nxt_grant = '0;
        sel_op    = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && i_req[k] && (IW'(k) >= rr_ptr)) begin
                found     = 1'b1;
                nxt_grant = IW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && i_req[k]) begin
                found     = 1'b1;
                nxt_grant = IW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == nxt_grant) begin
                sel_op = i_op[k];
                sel_a  = i_a[k*WIDTH +: WIDTH];
                sel_b  = i_b[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            wd_cnt       <= '0;
            o_ack        <= '0;
            o_result     <= '0;
            o_err        <= 1'b0;
            o_busy       <= 1'b0;
            o_unit_start <= 1'b0;
            o_unit_op    <= 1'b0;
            o_unit_a     <= '0;
            o_unit_b     <= '0;
        end else begin
            o_unit_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant        <= nxt_grant;
                        o_unit_op    <= sel_op;
                        o_unit_a     <= sel_a;
                        o_unit_b     <= sel_b;
                        o_unit_start <= 1'b1;
                        o_busy       <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Down-counter reaches zero on the TIMEOUT-th WAIT cycle.
                    wd_cnt <= CW'(TIMEOUT - 1);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_unit_done) begin
                        o_result <= i_unit_result;
                        o_err    <= 1'b0;
                        o_ack    <= NREQ'(1) << grant;
                        state    <= S_RESP;
                    end else if (wd_cnt == '0) begin
                        o_result <= '0;
                        o_err    <= 1'b1;
                        o_ack    <= NREQ'(1) << grant;
                        state    <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    o_ack    <= '0;
                    o_result <= '0;
                    o_err    <= 1'b0;
                    o_busy   <= 1'b0;
                    rr_ptr   <= (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modarith_arbiter.sv
// Bench for modarith_arbiter: mod-p stub unit, cycle-timing reference model, directed and random traffic.
module tb_modarith_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 256;
    localparam int TIMEOUT = 64;
    localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] P_MINUS_1 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2E;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       op = '0;
    logic [NREQ*WIDTH-1:0] a_bus = '0;
    logic [NREQ*WIDTH-1:0] b_bus = '0;
    logic                  unit_done = 1'b0;
    logic [WIDTH-1:0]      unit_result = '0;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      result;
    logic                  err, busy, ustart, uop;
    logic [WIDTH-1:0]      ua, ub;

    modarith_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_a(a_bus), .i_b(b_bus),
        .o_ack(ack), .o_result(result), .o_err(err), .o_busy(busy),
        .o_unit_start(ustart), .o_unit_op(uop), .o_unit_a(ua), .o_unit_b(ub),
        .i_unit_done(unit_done), .i_unit_result(unit_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mod_op(input logic o, input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        if (!o) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, P}) s = s - {1'b0, P};
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, P} - {1'b0, b};
        end
        return s[255:0];
    endfunction

    function automatic logic [255:0] rand_fe();
        logic [255:0] v;
        case ($urandom_range(0, 7))
            0: v = P_MINUS_1;
            1: v = '0;
            2: v = 256'd1;
            default: begin
                v = '1;
                while (v >= P)
                    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
            end
        endcase
        return v;
    endfunction

    function automatic int lane_of(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Reference model: outputs expected in the next cycle, derived from the timing rules
    // (start one cycle after grant, ack one cycle after done, ack at age TIMEOUT+2 on timeout).
    logic [NREQ-1:0]  e_ack = '0;
    logic [WIDTH-1:0] e_result = '0, e_a = '0, e_b = '0;
    logic             e_err = 0, e_busy = 0, e_start = 0, e_op = 0;
    bit               m_busy = 0, m_resp = 0;
    int               m_rr = 0, m_g = 0, m_age = 0, mj;

    always @(negedge clk) begin
        check("ack", WIDTH'(ack), WIDTH'(e_ack));
        check("err", WIDTH'(err), WIDTH'(e_err));
        check("busy", WIDTH'(busy), WIDTH'(e_busy));
        check("unit_start", WIDTH'(ustart), WIDTH'(e_start));
        if (e_ack != '0) check("result", result, e_result);
        if (m_busy && !m_resp) begin
            check("unit_op", WIDTH'(uop), WIDTH'(e_op));
            check("unit_a", ua, e_a);
            check("unit_b", ub, e_b);
        end
        if (rst) begin
            m_busy = 0; m_resp = 0; m_rr = 0; m_age = 0;
            e_ack = '0; e_result = '0; e_err = 0; e_busy = 0; e_start = 0;
            e_op = 0; e_a = '0; e_b = '0;
        end else if (m_resp) begin
            e_ack = '0; e_result = '0; e_err = 0; e_busy = 0; e_start = 0;
            m_rr = (m_g + 1) % NREQ;
            m_busy = 0; m_resp = 0;
        end else if (!m_busy) begin
            e_start = 0;
            if (req != '0) begin
                m_g = -1;
                for (int i = 0; i < NREQ; i++) begin
                    mj = (m_rr + i) % NREQ;
                    if (m_g < 0 && req[mj]) m_g = mj;
                end
                e_op = op[m_g];
                e_a = a_bus[m_g*WIDTH +: WIDTH];
                e_b = b_bus[m_g*WIDTH +: WIDTH];
                e_start = 1; e_busy = 1; m_busy = 1; m_age = 1;
            end
        end else begin
            e_start = 0;
            if (m_age >= 2) begin
                if (unit_done) begin
                    m_resp = 1; e_ack = '0; e_ack[m_g] = 1'b1;
                    e_result = mod_op(e_op, e_a, e_b); e_err = 0;
                end else if (m_age == TIMEOUT + 1) begin
                    m_resp = 1; e_ack = '0; e_ack[m_g] = 1'b1;
                    e_result = '0; e_err = 1;
                end
            end
            m_age++;
        end
    end

    // Requester protocol and stub unit, advanced once per cycle just after the rising edge.
    int               cyc = 0;
    int               stub_cnt = 0, stub_lat = 3;
    bit               stub_en = 1, stub_rand = 0, rearm = 0;
    logic [255:0]     stub_res = '0;
    logic [NREQ-1:0]  prev_ack = '0, last_drop = '0;

    task automatic step();
        logic [NREQ-1:0] drop;
        @(posedge clk);
        #1;
        cyc++;
        drop = prev_ack;
        req = req & ~drop;
        if (rearm)
            for (int k = 0; k < NREQ; k++)
                if (last_drop[k]) begin
                    req[k] = 1'b1;
                    op[k] = 1'($urandom);
                    a_bus[k*WIDTH +: WIDTH] = rand_fe();
                    b_bus[k*WIDTH +: WIDTH] = rand_fe();
                end
        last_drop = drop;
        prev_ack = ack;
        if (stub_cnt > 0) begin
            stub_cnt--;
            unit_done = (stub_cnt == 0);
        end else begin
            unit_done = 1'b0;
        end
        unit_result = unit_done ? stub_res : {8{$urandom}};
        if (ustart) begin
            stub_res = mod_op(uop, ua, ub);
            if (stub_rand) begin
                stub_lat = $urandom_range(1, 6);
                stub_cnt = ($urandom_range(0, 15) == 0) ? 0 : stub_lat;
            end else begin
                stub_cnt = stub_en ? stub_lat : 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; stub_cnt = 0;
        step();
        step();
        rst = 1'b0; prev_ack = '0; last_drop = '0;
    endtask

    task automatic run_single(input int k, input logic o, input logic [255:0] a, input logic [255:0] b,
                              input logic [255:0] exp_res, input int exp_rel, input logic exp_err,
                              input bit scramble, input string nm);
        int t0, srel, arel;
        logic [NREQ-1:0] got_ack;
        logic [255:0] got_res;
        logic got_err;
        logic [NREQ-1:0] exp_ack;
        srel = -1; arel = -1; got_ack = '0; got_res = '0; got_err = 1'b0;
        exp_ack = '0; exp_ack[k] = 1'b1;
        step();
        req[k] = 1'b1; op[k] = o;
        a_bus[k*WIDTH +: WIDTH] = a;
        b_bus[k*WIDTH +: WIDTH] = b;
        t0 = cyc;
        for (int i = 0; i < 100 && arel < 0; i++) begin
            step();
            if (ustart && srel < 0) srel = cyc - t0;
            if (scramble && cyc - t0 == 3) begin
                a_bus[k*WIDTH +: WIDTH] = ~a;
                b_bus[k*WIDTH +: WIDTH] = ~b;
            end
            if (scramble && cyc - t0 == 4) begin
                check({nm, "_hold_a"}, ua, a);
                check({nm, "_hold_b"}, ub, b);
            end
            if (ack != '0) begin
                arel = cyc - t0; got_ack = ack; got_res = result; got_err = err;
            end
        end
        check({nm, "_start_cycle"}, WIDTH'(srel), WIDTH'(1));
        check({nm, "_ack_cycle"}, WIDTH'(arel), WIDTH'(exp_rel));
        check({nm, "_ack"}, WIDTH'(got_ack), WIDTH'(exp_ack));
        check({nm, "_result"}, got_res, exp_res);
        check({nm, "_err"}, WIDTH'(got_err), WIDTH'(exp_err));
        step();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int order[5], when[5];
        int na, nlate, bseen, first;
        check("model_add_pin", mod_op(1'b0, P_MINUS_1, 256'd2), 256'd1);
        check("model_sub_pin", mod_op(1'b1, 256'd0, 256'd1), P_MINUS_1);

        repeat (3) step();
        rst = 1'b0;
        check("reset_outputs", WIDTH'({ack, err, busy, ustart, uop}), '0);
        check("reset_result", result, '0);
        check("reset_unit_ab", ua | ub, '0);

        run_single(0, 1'b0, P_MINUS_1, 256'd2, 256'd1, 5, 1'b0, 1'b1, "add");
        run_single(2, 1'b1, 256'd0, 256'd1, P_MINUS_1, 5, 1'b0, 1'b0, "sub");

        // Round robin with all four requesting and re-arming after each drop.
        do_reset();
        rearm = 1;
        for (int k = 0; k < NREQ; k++) begin
            req[k] = 1'b1; op[k] = 1'($urandom);
            a_bus[k*WIDTH +: WIDTH] = rand_fe();
            b_bus[k*WIDTH +: WIDTH] = rand_fe();
        end
        na = 0;
        for (int i = 0; i < 200 && na < 5; i++) begin
            step();
            if (ack != '0) begin
                order[na] = lane_of(ack); when[na] = cyc; na++;
            end
        end
        rearm = 0;
        req = '0;
        check("rr_ack_count", WIDTH'(na), WIDTH'(5));
        for (int i = 0; i < na; i++) check("rr_order", WIDTH'(order[i]), WIDTH'(i % NREQ));
        for (int i = 1; i < na; i++) check("rr_spacing", WIDTH'(when[i] - when[i-1]), WIDTH'(6));
        for (int i = 0; i < 100 && busy; i++) step();
        step();

        // Watchdog expiry, then a late done that must be ignored.
        stub_en = 0;
        run_single(0, 1'b0, rand_fe(), rand_fe(), 256'd0, TIMEOUT + 2, 1'b1, 1'b0, "timeout");
        stub_en = 1;
        step();
        unit_done = 1'b1;
        unit_result = {8{$urandom}};
        nlate = 0; bseen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack != '0) nlate++;
            if (busy) bseen++;
        end
        check("late_done_acks", WIDTH'(nlate), '0);
        check("late_done_busy", WIDTH'(bseen), '0);

        // Reset in cycle 2 of an operation; the stub still delivers done in cycle 4.
        step();
        req[2] = 1'b1; op[2] = 1'b0;
        a_bus[2*WIDTH +: WIDTH] = rand_fe();
        b_bus[2*WIDTH +: WIDTH] = rand_fe();
        step();
        step();
        rst = 1'b1; req = '0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rst_wait_outputs", WIDTH'({ack, err, busy, ustart, uop}), '0);
            check("rst_wait_data", result | ua | ub, '0);
            step();
        end
        req = '1;
        first = -1;
        for (int i = 0; i < 100 && first < 0; i++) begin
            step();
            if (ack != '0) first = lane_of(ack);
        end
        check("rst_first_grant", WIDTH'(first), '0);
        req = '0;
        for (int i = 0; i < 100 && busy; i++) step();
        step();

        // Random traffic with variable latency, no-response ops, idle done pulses and resets.
        stub_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1; stub_cnt = 0; unit_done = 1'b0; req = '0;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!req[k] && !last_drop[k] && $urandom_range(0, 3) == 0) begin
                        req[k] = 1'b1; op[k] = 1'($urandom);
                        a_bus[k*WIDTH +: WIDTH] = rand_fe();
                        b_bus[k*WIDTH +: WIDTH] = rand_fe();
                    end else if (req[k] && $urandom_range(0, 7) == 0) begin
                        a_bus[k*WIDTH +: WIDTH] = rand_fe();
                        b_bus[k*WIDTH +: WIDTH] = rand_fe();
                    end
                end
                if (!busy && stub_cnt == 0 && !unit_done && $urandom_range(0, 15) == 0) begin
                    unit_done = 1'b1;
                    unit_result = {8{$urandom}};
                end
            end
        end
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < 200 && busy; i++) step();
        check("drain_idle", WIDTH'(busy), '0);
        step();
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/modarith_arbiter.md
# modarith_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle 256-bit modular add/sub unit (secp256k1 field, p = 2^256 − 2^32 − 977) among NREQ requesters. It accepts one operation at a time and latches the winning requester's operands. It drives the unit through a start/done handshake and returns the result with a one-cycle acknowledge. A watchdog bounds how long the block waits for the unit. It sits between the point-arithmetic sequencers and the shared modular adder/subtractor.

## Interface

- NREQ, 4, number of requesters (2..8)
- WIDTH, 256, operand/result width
- TIMEOUT, 64, max cycles waited for i_unit_done before abort (≥ 2)

Ports:

- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  NREQ  per-requester request level; held until its o_ack cycle, dropped the cycle after
- i_op  in  NREQ  per-requester op: 0 = add, 1 = sub
- i_a  in  NREQ*WIDTH  operand A, requester k at bits [k*WIDTH +: WIDTH]
- i_b  in  NREQ*WIDTH  operand B, same packing
- o_ack  out  NREQ  one-hot, one-cycle completion pulse to the served requester
- o_result  out  WIDTH  result, valid only while o_ack != 0
- o_err  out  1  high with o_ack when the operation timed out
- o_busy  out  1  high in any state other than IDLE
- o_unit_start  out  1  one-cycle start pulse to the shared unit
- o_unit_op  out  1  latched op, stable from ISSUE through WAIT
- o_unit_a / o_unit_b  out  WIDTH  latched operands, stable from ISSUE through WAIT
- i_unit_done  in  1  unit completion pulse
- i_unit_result  in  WIDTH  unit result, valid with i_unit_done

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If i_req is nonzero, grant the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Latch the grant index g, i_op[g], the A slice and the B slice. Go to ISSUE.
  - If i_req is zero, stay in IDLE.
- **ISSUE**
  - o_unit_start = 1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- **WAIT**
  - On i_unit_done: capture i_unit_result into the result register and clear the error flag. Go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT−1 with no done: set the error flag, force the result register to 0, go to RESP.
- **RESP**
  - o_ack[g] = 1, o_result = result register, o_err = error flag.
  - Set rr_ptr = (g+1) mod NREQ. Go to IDLE.
- i_req changes outside IDLE are ignored. Operands are latched once, in IDLE only.
- i_unit_done outside WAIT is ignored, including a late done after a timeout.
- Simultaneous done and timeout in the same WAIT cycle: done wins and o_err = 0.
- Operands and results pass through unmodified; this block does no arithmetic. Range checking (< p) is the unit's responsibility.
- **Reset** (also when asserted mid-operation)
  - State = IDLE, rr_ptr = 0, watchdog = 0.
  - o_ack = 0, o_result = 0, o_err = 0, o_busy = 0, o_unit_start = 0, o_unit_op = 0, o_unit_a = 0, o_unit_b = 0.
  - An in-flight operation is abandoned with no ack.
  - A stale i_unit_done after reset is ignored because the FSM is in IDLE.

## Timing

- All outputs are registered. Nothing combinational runs from i_req or i_unit_done to any output.
- Request first seen in IDLE at cycle 0:
  - o_unit_start in cycle 1.
  - If the unit raises i_unit_done in cycle 1+L (L ≥ 1), o_ack is in cycle 2+L.
  - Next IDLE is cycle 3+L.
- Minimum per-operation occupancy: L+3 cycles. Back-to-back grants have no extra bubble beyond the IDLE cycle.
- Timeout: o_ack with o_err = 1 occurs in cycle TIMEOUT+2 after the grant.
- o_busy goes high in cycle 1 and low in cycle 3+L.
- Fairness: with all NREQ requesting continuously, grants follow 0,1,…,NREQ−1,0,… Worst-case wait is (NREQ−1) operations.

## Test plan

Stub unit: mod-p add/sub with latency L = 3.

- **Single add.** Reset, then req0 add, a = p−1 (…FFFFFC2E), b = 2.
  - Required: o_unit_start in cycle 1; o_ack = 4'b0001 in cycle 5; o_result = 1; o_err = 0.
- **Single sub.** req2 sub, a = 0, b = 1.
  - Required: o_ack = 4'b0100; o_result = p−1 = FFFFFFFF…FFFFFFFEFFFFFC2E.
- **Round-robin.** All four requests asserted together; each drops the cycle after its own ack, then re-asserts.
  - Required: ack order 0,1,2,3,0; acks spaced 6 cycles apart.
- **Timeout.** Stub never asserts done, TIMEOUT = 64.
  - Required: o_ack plus o_err = 1 and o_result = 0 at cycle 66.
  - Then inject a late done: no second ack, FSM stays IDLE.
- **Reset mid-WAIT.** Assert i_rst in cycle 2 of an operation, then deliver the stub's done in cycle 4.
  - Required: all outputs 0, no ack, rr_ptr = 0.
  - Next request is served by requester 0 first when all are requesting.
- **Operand stability.** Change i_a and i_b of the granted requester during WAIT.
  - Required: o_unit_a and o_unit_b keep their latched values; the result reflects the latched operands.
